// File: rtl/rom_scan_pkg.sv
// Shared definitions for the ROM address sequencer.
// Holds the FSM state encoding and the default ROM geometry. ROM_DEPTH
// doubles as the window check limit: a window whose last index is at or
// beyond it is rejected at start.
package rom_scan_pkg;

  localparam int unsigned ROM_SIZE  = 6;   // ROM word width
  localparam int unsigned ROM_DEPTH = 28;  // valid entries; last must be below this
  localparam int unsigned ROM_AW    = 5;   // ROM select width
  localparam int unsigned ROM_CW    = 8;   // accepted-word counter width

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/rom_scan_seq.sv
// rom_scan_seq: walks an index window [first, last] over an external
// combinational ROM, registers each word and offers it on a valid/ready
// stream. One-shot or continuous-loop scans, abort, done pulse.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               scan request, sampled in IDLE only
//   first, last         index window, sampled with start
//   loop_en             wrap from last back to first, sampled with start
//   abort               terminate scan (wins over start)
//   rom_sel / rom_data  ROM select out, combinational ROM word in
//   out_data/out_valid  registered word stream to the consumer
//   out_ready           consumer accept
//   busy                high in any state except IDLE
//   done                one-cycle pulse at the end of a one-shot scan
//   cfg_err             one-cycle pulse when start is rejected
//   count               words accepted since the last start, wraps
module rom_scan_seq
  import rom_scan_pkg::*;
#(
  parameter int unsigned SIZE  = ROM_SIZE,
  parameter int unsigned DEPTH = ROM_DEPTH,
  parameter int unsigned AW    = ROM_AW,
  parameter int unsigned CW    = ROM_CW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   first,
  input  logic [AW-1:0]   last,
  input  logic            loop_en,
  input  logic            abort,
  output logic [AW-1:0]   rom_sel,
  input  logic [SIZE-1:0] rom_data,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            cfg_err,
  output logic [CW-1:0]   count
);

  state_t state, state_nxt;

  logic [AW-1:0] first_q;
  logic [AW-1:0] last_q;
  logic          loop_q;

  logic cfg_ok;
  logic hs;
  logic at_last;

  assign cfg_ok  = (first <= last) && (32'(last) < DEPTH);
  assign hs      = out_valid && out_ready;
  assign at_last = (rom_sel == last_q);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start && cfg_ok) state_nxt = FETCH;
        FETCH:   state_nxt = HOLD;
        HOLD:    if (hs) state_nxt = (at_last && !loop_q) ? DONE : FETCH;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath. Abort is checked first so a word sitting in HOLD is dropped
  // without counting even if the consumer accepts it in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_sel   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      count     <= '0;
      first_q   <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (abort) begin
        out_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                first_q <= first;
                last_q  <= last;
                loop_q  <= loop_en;
                rom_sel <= first;
                count   <= '0;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          FETCH: begin
            out_data  <= rom_data;
            out_valid <= 1'b1;
          end
          HOLD: begin
            if (hs) begin
              count     <= count + CW'(1);
              out_valid <= 1'b0;
              if (at_last) begin
                if (loop_q) rom_sel <= first_q;
              end else begin
                rom_sel <= rom_sel + AW'(1);
              end
            end
          end
          DONE: ;
          default: ;
        endcase
      end
    end
  end

endmodule
